mem_responder: RTL

//  Memory-side responder for the MEM stage's load/store request interface.

---
 rtl/mem_responder_if.sv | 29 ++
 rtl/mem_responder.sv | 100 ++++++++++
 2 files changed

// File: rtl/mem_responder_if.sv
// Load/store request bus between the MEM stage (master) and mem_responder (slave).
// range_err exists only when RANGE_CHECK_EN is defined.
interface mem_responder_if;
  logic        mem_read_enable;
  logic        mem_write_enable;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        mem_ready;
  logic [31:0] read_data;
`ifdef RANGE_CHECK_EN
  logic        range_err;
`endif

  modport master (
    output mem_read_enable, mem_write_enable, address, write_data,
`ifdef RANGE_CHECK_EN
    input  range_err,
`endif
    input  mem_ready, read_data
  );

  modport slave (
    input  mem_read_enable, mem_write_enable, address, write_data,
`ifdef RANGE_CHECK_EN
    output range_err,
`endif
    output mem_ready, read_data
  );
endinterface

// File: rtl/mem_responder.sv
// Word store answering MEM-stage loads/stores after WAIT_CYCLES wait cycles.
// Optional feature: RANGE_CHECK_EN adds out-of-range detection and range_err.
module mem_responder #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 5
) (
  input logic            clk,
  input logic            rst,
  mem_responder_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             op_write;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      data_q;
  logic             oor_q;
  logic [31:0]      read_data_q;
  logic [31:0]      store [DEPTH];

  logic             req;
  logic [31:0]      addr_off;
  logic [IDX_W-1:0] idx;
  logic             oor;
  logic             unused_addr;

  assign req      = bus.mem_read_enable | bus.mem_write_enable;
  assign addr_off = bus.address - 32'(BASE_ADDR);
  assign idx      = addr_off[IDX_W+1:2];
  // Upper offset bits only matter to the range check; byte lane is ignored.
  assign unused_addr = ^{addr_off[31:IDX_W+2], addr_off[1:0]};

`ifdef RANGE_CHECK_EN
  logic range_err_q;
  assign oor = (bus.address < 32'(BASE_ADDR)) || ((addr_off >> 2) >= 32'(DEPTH));
  assign bus.range_err = range_err_q;
`else
  assign oor = 1'b0;
`endif

  assign bus.mem_ready = ((state == IDLE) && !req) || (state == DONE);
  assign bus.read_data = read_data_q;

  // Access FSM; the request is captured in IDLE and committed on the last WAIT edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      op_write    <= 1'b0;
      idx_q       <= '0;
      data_q      <= '0;
      oor_q       <= 1'b0;
      read_data_q <= '0;
`ifdef RANGE_CHECK_EN
      range_err_q <= 1'b0;
`endif
      for (int i = 0; i < int'(DEPTH); i++) store[i] <= '0;
    end else begin
`ifdef RANGE_CHECK_EN
      range_err_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (req) begin
            op_write <= bus.mem_write_enable;
            idx_q    <= idx;
            data_q   <= bus.write_data;
            oor_q    <= oor;
            cnt      <= CNT_W'(WAIT_CYCLES - 1);
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            if (op_write) begin
              if (!oor_q) store[idx_q] <= data_q;
            end else begin
              read_data_q <= oor_q ? 32'h0 : store[idx_q];
            end
`ifdef RANGE_CHECK_EN
            range_err_q <= oor_q;
`endif
            state <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
